mux_4_1_rr_arbiter: RTL and testbench
=====================================

# mux_4_1_rr_arbiter

Round-robin arbiter and sequencer for the 4:1 data mux. It shares one output channel among four requesters (a, b, c, d) and drives the mux select from a registered grant. Each grant carries up to MAX_HOLD beats over a valid/ready handshake. It sits between the four source blocks and the single downstream consumer of the muxed 4-bit stream.

## Interface
- WIDTH, 4: data width of each input and of the output.
- MAX_HOLD, 4: maximum beats transferred per grant before forced rotation. Legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  request per source; bit 0 = a, 1 = b, 2 = c, 3 = d.
- a, b, c, d  in  WIDTH  source data.
- gnt  out  4  one-hot registered grant; all-zero when idle.
- sel  out  2  registered mux select; index of the current or last grant.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts a beat.
- out  out  WIDTH  selected data when out_valid, else 0.
- busy  out  1  high while in the GRANT state.

## Operation
- Reset values: gnt=0, sel=0, busy=0, out_valid=0, out=0. Internal: state=IDLE, rotation pointer ptr=0, beat count cnt=0.
- State machine with two states, IDLE and GRANT.
- **IDLE**
  - If req != 0, the winner is the first set bit of req found by scanning from ptr upward, modulo 4.
  - Next cycle: state=GRANT, gnt=onehot(winner), sel=winner, cnt=0.
  - If req == 0, stay in IDLE.
- **GRANT**
  - out_valid = req[sel] (combinational).
  - out = mux(sel) of a/b/c/d when out_valid, else 0.
  - A transfer occurs when out_valid && out_ready. Each transfer increments cnt.
- **Release conditions**, evaluated each GRANT cycle:
  - (1) req[sel]==0, or
  - (2) a transfer occurs with cnt==MAX_HOLD-1.
  - On release, next cycle: state=IDLE, gnt=0, ptr=(sel+1) mod 4, cnt=0. sel keeps its last value.
- Fairness: after any grant to source i, the next grant priority order is i+1, i+2, i+3, i (mod 4).
- Requests from non-granted sources are ignored in GRANT. They have no effect on out, out_valid or cnt.
- cnt is 4 bits and never exceeds MAX_HOLD-1.
- Arithmetic:
  - ptr and sel increments wrap 3 -> 0.
  - Scan with ptr=3 checks d, then a, b, c.
- Asserting rst_n low at any point, including mid-grant with a transfer pending, immediately forces all reset values. No beat is counted as transferred in that cycle.

## Timing
- Grant latency: req first high at edge n (while IDLE) -> gnt, sel, busy valid after edge n+1. out_valid is high in that same cycle if req is still high.
- Release costs exactly one IDLE bubble cycle. A new grant is visible at the second edge after the releasing cycle.
- Max throughput: MAX_HOLD beats per MAX_HOLD+1 cycles under continuous requests and out_ready=1.
- out_ready low only stalls: cnt holds and the grant holds. Holding has no timeout.
- Source drops req in the same cycle that out_ready is high: no transfer (out_valid=0), and release via condition (1).
- Condition (2) with req still high: the grant releases anyway, and the same source competes again only after the other pending sources.
- Simultaneous requests in IDLE are resolved purely by ptr order.

## Test plan
- **Reset:** rst_n=0 with req=4'b1111 -> gnt=0, sel=0, out_valid=0, out=0, busy=0. Release reset, hold req=4'b0100 -> gnt=4'b0100, sel=2 one cycle later, and out equals c.
- **Round robin:** req=4'b1111, out_ready=1, MAX_HOLD=4 -> grant order a, b, c, d, a. Each grant has 4 transfers followed by 1 idle cycle, and out tracks the granted input.
- **Early release:** grant b; b drops req after 2 transfers while req=4'b1001 -> next grant d, ptr=2 scan order c, d; cnt resets.
- **Backpressure:** grant a, out_ready=0 for 5 cycles -> out_valid=1, cnt stays 0, gnt stays 4'b0001. Then out_ready=1 -> 4 transfers and release.
- **Wrap-around:** last grant d (ptr=0), req=4'b0011 -> grant a. Separately with ptr=3 and req=4'b0111 -> grant a, not b.
- **Mid-grant reset:** pull rst_n low during beat 2 of a c grant with out_ready=1 -> all outputs 0 immediately. After release, req=4'b1100 -> grant c (ptr=0 scan order c, d).

Source files
------------

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter and sequencer for a 4:1 data mux.
// Four sources share one valid/ready output channel; each grant carries up
// to MAX_HOLD beats before the grant rotates to the next pending source.
module mux_4_1_rr_arbiter #(
   parameter int WIDTH    = 4,
   parameter int MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   output logic [3:0]       gnt,
   output logic [1:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             busy
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state;
   logic [1:0] ptr;
   logic [3:0] cnt;
   logic [1:0] win;
   logic       hit;
   logic [1:0] idx;
   logic       xfer;
   logic       last_beat;

   // Scan req starting at ptr and wrapping; the lowest offset from ptr wins.
   always_comb begin
      win = ptr;
      hit = 1'b0;
      idx = ptr;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (req[idx]) begin
            win = idx;
            hit = 1'b1;
         end
      end
   end

   assign busy      = (state == GRANT);
   assign out_valid = busy && req[sel];
   assign xfer      = out_valid && out_ready;
   assign last_beat = xfer && (cnt == 4'(MAX_HOLD - 1));

   // Output data mux; forced to zero whenever no beat is offered.
   always_comb begin
      out = '0;
      if (out_valid) begin
         case (sel)
            2'd0:    out = a;
            2'd1:    out = b;
            2'd2:    out = c;
            default: out = d;
         endcase
      end
   end

   // Grant FSM: pick a winner in IDLE, count beats in GRANT, rotate on release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= '0;
         sel   <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (hit) begin
                  state <= GRANT;
                  gnt   <= 4'b0001 << win;
                  sel   <= win;
                  cnt   <= '0;
               end
            end
            GRANT: begin
               // Dropped request or a full burst both end the grant; sel is kept.
               if (!req[sel] || last_beat) begin
                  state <= IDLE;
                  gnt   <= '0;
                  ptr   <= sel + 2'd1;
                  cnt   <= '0;
               end else if (xfer) begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Directed bench for mux_4_1_rr_arbiter with hand-computed expectations.
module tb_mux_4_1_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] a = 4'hA, b = 4'hB, c = 4'hC, d = 4'hD;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [3:0] out;
   logic       busy;

   int n_chk  = 0;
   int n_fail = 0;

   logic [3:0] data_tab [4];

   mux_4_1_rr_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .a(a), .b(b), .c(c), .d(d),
      .gnt(gnt), .sel(sel), .out_valid(out_valid),
      .out_ready(out_ready), .out(out), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; return 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold reset across two edges, release it away from the edge.
   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      data_tab[0] = 4'hA; data_tab[1] = 4'hB; data_tab[2] = 4'hC; data_tab[3] = 4'hD;

      // Reset with all requests asserted
      req = 4'b1111;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_vld", 32'(out_valid), 32'h0);
      chk("rst_out", 32'(out), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      req = 4'b0100;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      chk("first_gnt", 32'(gnt), 32'h4);
      chk("first_sel", 32'(sel), 32'h2);
      chk("first_busy", 32'(busy), 32'h1);
      chk("first_out", 32'(out), 32'hC);
      // Drop c immediately: no beat, release, ptr becomes 3
      req = 4'b0000;
      #1;
      chk("drop_vld", 32'(out_valid), 32'h0);
      chk("drop_out", 32'(out), 32'h0);
      step();
      chk("drop_gnt", 32'(gnt), 32'h0);
      chk("drop_sel_kept", 32'(sel), 32'h2);
      // ptr=3, req=0111 scans d, a -> a
      req = 4'b0111;
      step();
      chk("wrap3_gnt", 32'(gnt), 32'h1);
      chk("wrap3_sel", 32'(sel), 32'h0);

      // Round robin, continuous requests, full bursts
      req = 4'b1111;
      out_ready = 1'b1;
      do_reset();
      for (int g = 0; g < 5; g++) begin
         for (int bt = 0; bt < 4; bt++) begin
            step();
            chk($sformatf("rr_gnt%0d_%0d", g, bt), 32'(gnt), 32'(4'b0001 << (g % 4)));
            chk($sformatf("rr_out%0d_%0d", g, bt), 32'(out), 32'(data_tab[g % 4]));
         end
         step();
         chk($sformatf("rr_idle%0d", g), 32'(busy), 32'h0);
         chk($sformatf("rr_idle_vld%0d", g), 32'(out_valid), 32'h0);
      end

      // Early release of b after two beats
      req = 4'b0010;
      do_reset();
      step();
      chk("er_gnt_b", 32'(gnt), 32'h2);
      step();
      step();
      chk("er_hold_b", 32'(gnt), 32'h2);
      req = 4'b1001;
      #1;
      chk("er_vld", 32'(out_valid), 32'h0);
      step();
      chk("er_idle", 32'(gnt), 32'h0);
      chk("er_sel_kept", 32'(sel), 32'h1);
      step();
      chk("er_gnt_d", 32'(gnt), 32'h8);
      chk("er_sel_d", 32'(sel), 32'h3);
      chk("er_out_d", 32'(out), 32'hD);
      for (int bt = 1; bt < 4; bt++) begin
         step();
         chk($sformatf("er_d_beat%0d", bt), 32'(gnt), 32'h8);
      end
      step();
      chk("er_d_release", 32'(gnt), 32'h0);

      // Backpressure on a
      req = 4'b0001;
      out_ready = 1'b0;
      do_reset();
      step();
      for (int s = 0; s < 5; s++) begin
         chk($sformatf("bp_gnt%0d", s), 32'(gnt), 32'h1);
         chk($sformatf("bp_vld%0d", s), 32'(out_valid), 32'h1);
         step();
      end
      out_ready = 1'b1;
      for (int bt = 0; bt < 4; bt++) begin
         chk($sformatf("bp_xfer%0d", bt), 32'(gnt), 32'h1);
         step();
      end
      chk("bp_release", 32'(gnt), 32'h0);

      // Wrap: last grant d leaves ptr=0, req=0011 -> a
      req = 4'b1000;
      do_reset();
      step();
      chk("w0_gnt_d", 32'(gnt), 32'h8);
      req = 4'b0000;
      step();
      chk("w0_idle", 32'(gnt), 32'h0);
      req = 4'b0011;
      step();
      chk("w0_gnt_a", 32'(gnt), 32'h1);

      // Mid-grant reset during c's second beat
      req = 4'b0100;
      out_ready = 1'b1;
      do_reset();
      step();
      chk("mr_gnt_c", 32'(gnt), 32'h4);
      step();
      rst_n = 1'b0;
      #1;
      chk("mr_gnt", 32'(gnt), 32'h0);
      chk("mr_vld", 32'(out_valid), 32'h0);
      chk("mr_out", 32'(out), 32'h0);
      chk("mr_busy", 32'(busy), 32'h0);
      chk("mr_sel", 32'(sel), 32'h0);
      req = 4'b1100;
      step();
      rst_n = 1'b1;
      step();
      chk("mr_regrant", 32'(gnt), 32'h4);
      chk("mr_regrant_sel", 32'(sel), 32'h2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
